// File: rtl/dsp_mac_if.sv
// Operand/result bundle for the dsp_mac_slice arithmetic tile.
// The master side drives operands and control; the slave side returns results.
interface dsp_mac_if #(
    parameter int unsigned A_WIDTH = 18,
    parameter int unsigned B_WIDTH = 18,
    parameter int unsigned P_WIDTH = 48
);
    logic                 ce_i;
    logic                 in_valid_i;
    logic [A_WIDTH-1:0]   a_i;
    logic [B_WIDTH-1:0]   b_i;
    logic [B_WIDTH-1:0]   d_i;
    logic [P_WIDTH-1:0]   c_i;
    logic [P_WIDTH-1:0]   pcin_i;
    logic                 carryin_i;
    logic [4:0]           opmode_i;
    logic [P_WIDTH-1:0]   p_o;
    logic [P_WIDTH-1:0]   pcout_o;
    logic [B_WIDTH-1:0]   bcout_o;
    logic                 out_valid_o;
    logic                 overflow_o;
    logic                 patdet_o;

    modport master (
        output ce_i, in_valid_i, a_i, b_i, d_i, c_i, pcin_i, carryin_i, opmode_i,
        input  p_o, pcout_o, bcout_o, out_valid_o, overflow_o, patdet_o
    );

    modport slave (
        input  ce_i, in_valid_i, a_i, b_i, d_i, c_i, pcin_i, carryin_i, opmode_i,
        output p_o, pcout_o, bcout_o, out_valid_o, overflow_o, patdet_o
    );
endinterface

// File: rtl/dsp_mac_slice.sv
// Three-stage signed MAC slice: pre-adder, multiplier, post-adder/accumulator
// with valid tracking, overflow saturation/wrap and registered pattern detect.
module dsp_mac_slice #(
    parameter int unsigned        A_WIDTH  = 18,
    parameter int unsigned        B_WIDTH  = 18,
    parameter int unsigned        P_WIDTH  = 48,
    parameter bit                 SATURATE = 1'b1,
    parameter logic [P_WIDTH-1:0] PATTERN  = '0,
    parameter logic [P_WIDTH-1:0] MASK     = '0
) (
    input logic          clk,
    input logic          rst_n,
    dsp_mac_if.slave     bus
);
    localparam int unsigned PRE_W = B_WIDTH + 1;
    localparam int unsigned M_W   = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned S_W   = P_WIDTH + 2;

    localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Stage 1
    logic signed [A_WIDTH-1:0] a1_q, a1_d;
    logic signed [B_WIDTH-1:0] b1_q, b1_d;
    logic signed [B_WIDTH-1:0] d1_q, d1_d;
    logic [P_WIDTH-1:0]        c1_q, c1_d;
    logic [4:0]                op1_q, op1_d;
    logic                      cin1_q, cin1_d;
    logic                      v1_q, v1_d;

    // Stage 2
    logic signed [M_W-1:0]     m2_q, m2_d;
    logic [P_WIDTH-1:0]        c2_q, c2_d;
    logic [4:0]                op2_q, op2_d;
    logic                      cin2_q, cin2_d;
    logic                      v2_q, v2_d;

    // Stage 3 / outputs
    logic [P_WIDTH-1:0]        p_q, p_d;
    logic                      ovf_q, ovf_d;
    logic                      pat_q, pat_d;
    logic                      ov_q, ov_d;

    logic signed [PRE_W-1:0]   pre;
    logic [P_WIDTH-1:0]        z;
    logic [S_W-1:0]            z_ext, m_ext, cin_ext, sum;
    logic                      sum_ovf;
    logic [P_WIDTH-1:0]        p_next;

    // Datapath and next-state; every register holds unless CE (and, for P, valid).
    always_comb begin
        a1_d   = a1_q;
        b1_d   = b1_q;
        d1_d   = d1_q;
        c1_d   = c1_q;
        op1_d  = op1_q;
        cin1_d = cin1_q;
        v1_d   = v1_q;
        m2_d   = m2_q;
        c2_d   = c2_q;
        op2_d  = op2_q;
        cin2_d = cin2_q;
        v2_d   = v2_q;
        p_d    = p_q;
        ovf_d  = ovf_q;
        pat_d  = pat_q;
        ov_d   = ov_q;

        case (op1_q[1:0])
            2'b01:   pre = PRE_W'(d1_q) + PRE_W'(b1_q);
            2'b10:   pre = PRE_W'(d1_q) - PRE_W'(b1_q);
            default: pre = PRE_W'(b1_q);
        endcase

        case (op2_q[3:2])
            2'b00:   z = '0;
            2'b01:   z = c2_q;
            2'b10:   z = p_q;
            default: z = bus.pcin_i;
        endcase

        // Exact sum with two guard bits; overflow when the guard bits disagree with the sign.
        z_ext   = S_W'($signed(z));
        m_ext   = S_W'(m2_q);
        cin_ext = S_W'(cin2_q);
        if (op2_q[4]) sum = z_ext - (m_ext + cin_ext);
        else          sum = z_ext + m_ext + cin_ext;
        sum_ovf = ~((&sum[S_W-1:P_WIDTH-1]) | ~(|sum[S_W-1:P_WIDTH-1]));

        if (SATURATE && sum_ovf) p_next = sum[S_W-1] ? P_MIN : P_MAX;
        else                     p_next = sum[P_WIDTH-1:0];

        if (bus.ce_i) begin
            a1_d   = bus.a_i;
            b1_d   = bus.b_i;
            d1_d   = bus.d_i;
            c1_d   = bus.c_i;
            op1_d  = bus.opmode_i;
            cin1_d = bus.carryin_i;
            v1_d   = bus.in_valid_i;

            m2_d   = M_W'(a1_q) * M_W'(pre);
            c2_d   = c1_q;
            op2_d  = op1_q;
            cin2_d = cin1_q;
            v2_d   = v1_q;

            ov_d   = v2_q;
            if (v2_q) begin
                p_d   = p_next;
                ovf_d = sum_ovf;
                pat_d = (((p_next ^ PATTERN) & ~MASK) == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q   <= '0;
            b1_q   <= '0;
            d1_q   <= '0;
            c1_q   <= '0;
            op1_q  <= '0;
            cin1_q <= 1'b0;
            v1_q   <= 1'b0;
            m2_q   <= '0;
            c2_q   <= '0;
            op2_q  <= '0;
            cin2_q <= 1'b0;
            v2_q   <= 1'b0;
            p_q    <= '0;
            ovf_q  <= 1'b0;
            pat_q  <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            d1_q   <= d1_d;
            c1_q   <= c1_d;
            op1_q  <= op1_d;
            cin1_q <= cin1_d;
            v1_q   <= v1_d;
            m2_q   <= m2_d;
            c2_q   <= c2_d;
            op2_q  <= op2_d;
            cin2_q <= cin2_d;
            v2_q   <= v2_d;
            p_q    <= p_d;
            ovf_q  <= ovf_d;
            pat_q  <= pat_d;
            ov_q   <= ov_d;
        end
    end

    assign bus.p_o         = p_q;
    assign bus.pcout_o     = p_q;
    assign bus.bcout_o     = b1_q;
    assign bus.out_valid_o = ov_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.patdet_o    = pat_q;
endmodule

// File: tb/tb_dsp_mac_slice.sv
// Directed bench for dsp_mac_slice: one saturating and one wrapping instance
// driven with identical operands, checked against hand-computed results.
module tb_dsp_mac_slice;
    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        in_valid;
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic        cin;
    logic [4:0]  opmode;

    int n_cmp = 0;
    int n_err = 0;

    dsp_mac_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) bus_s ();
    dsp_mac_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) bus_w ();

    assign bus_s.ce_i = ce;         assign bus_w.ce_i = ce;
    assign bus_s.in_valid_i = in_valid; assign bus_w.in_valid_i = in_valid;
    assign bus_s.a_i = a;           assign bus_w.a_i = a;
    assign bus_s.b_i = b;           assign bus_w.b_i = b;
    assign bus_s.d_i = d;           assign bus_w.d_i = d;
    assign bus_s.c_i = c;           assign bus_w.c_i = c;
    assign bus_s.pcin_i = pcin;     assign bus_w.pcin_i = pcin;
    assign bus_s.carryin_i = cin;   assign bus_w.carryin_i = cin;
    assign bus_s.opmode_i = opmode; assign bus_w.opmode_i = opmode;

    dsp_mac_slice #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SATURATE(1'b1),
                    .PATTERN(48'h0), .MASK(48'h0))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    dsp_mac_slice #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SATURATE(1'b0),
                    .PATTERN(48'h0), .MASK(48'h0))
        u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic [17:0] ai, input logic [17:0] bi,
                          input logic [17:0] di, input logic [47:0] ci,
                          input logic [1:0] presel, input logic [1:0] zsel,
                          input logic sub, input logic ci_n);
        in_valid = v;
        a        = ai;
        b        = bi;
        d        = di;
        c        = ci;
        opmode   = {sub, zsel, presel};
        cin      = ci_n;
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        pcin  = '0;
        set_op(1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state (pattern 0 would match P=0, but PATDET must stay low)
        chk("rst_p",      64'(bus_s.p_o), 64'd0);
        chk("rst_bcout",  64'(bus_s.bcout_o), 64'd0);
        chk("rst_valid",  64'(bus_s.out_valid_o), 64'd0);
        chk("rst_ovf",    64'(bus_s.overflow_o), 64'd0);
        chk("rst_patdet", 64'(bus_s.patdet_o), 64'd0);
        rst_n = 1'b1;

        // Pre-add: (25+10)*20 + 350 + 1 = 1051
        set_op(1'b1, 18'd20, 18'd10, 18'd25, 48'd350, 2'b01, 2'b01, 1'b0, 1'b1);
        tick();
        chk("pre_bcout", 64'(bus_s.bcout_o), 64'd10);
        chk("pre_v1",    64'(bus_s.out_valid_o), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("pre_v2",    64'(bus_s.out_valid_o), 64'd0);
        tick();
        chk("pre_p",     64'(bus_s.p_o), 64'd1051);
        chk("pre_pcout", 64'(bus_s.pcout_o), 64'd1051);
        chk("pre_v3",    64'(bus_s.out_valid_o), 64'd1);
        chk("pre_ovf",   64'(bus_s.overflow_o), 64'd0);
        tick();
        chk("pre_v4",    64'(bus_s.out_valid_o), 64'd0);
        chk("pre_hold",  64'(bus_s.p_o), 64'd1051);

        // Mid-flight reset with three ops in the pipe
        set_op(1'b1, 18'd20, 18'd10, 18'd25, 48'd350, 2'b01, 2'b01, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_p",     64'(bus_s.p_o), 64'd0);
        chk("mrst_pcout", 64'(bus_s.pcout_o), 64'd0);
        chk("mrst_bcout", 64'(bus_s.bcout_o), 64'd0);
        chk("mrst_valid", 64'(bus_s.out_valid_o), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_idle_valid", 64'(bus_s.out_valid_o), 64'd0);
        end

        // Accumulate 3*4 with a bubble on cycle 2
        set_op(1'b1, 18'd3, 18'd4, 18'd0, 48'd0, 2'b00, 2'b10, 1'b0, 1'b0);
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("acc_p0", 64'(bus_s.p_o), 64'd12);
        chk("acc_v0", 64'(bus_s.out_valid_o), 64'd1);
        in_valid = 1'b1;
        tick();
        chk("acc_p1", 64'(bus_s.p_o), 64'd24);
        chk("acc_v1", 64'(bus_s.out_valid_o), 64'd1);
        tick();
        chk("acc_p2", 64'(bus_s.p_o), 64'd24);
        chk("acc_v2", 64'(bus_s.out_valid_o), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("acc_p3", 64'(bus_s.p_o), 64'd36);
        tick();
        chk("acc_p4", 64'(bus_s.p_o), 64'd48);
        chk("acc_v4", 64'(bus_s.out_valid_o), 64'd1);

        // Positive overflow: saturate vs wrap
        set_op(1'b1, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 2'b00, 2'b01, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("sat_p",     64'(bus_s.p_o), 64'h7FFF_FFFF_FFFF);
        chk("sat_ovf",   64'(bus_s.overflow_o), 64'd1);
        chk("wrap_p",    64'(bus_w.p_o), 64'h8000_0000_0000);
        chk("wrap_ovf",  64'(bus_w.overflow_o), 64'd1);

        // Subtract: 100 - (-3*7) = 121, then D-B = 0 -> P = 0 matches pattern
        set_op(1'b1, 18'h3FFFD, 18'd7, 18'd0, 48'd100, 2'b00, 2'b01, 1'b1, 1'b0);
        tick();
        set_op(1'b1, 18'h3FFFD, 18'd5, 18'd5, 48'd0, 2'b10, 2'b00, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("sub_p",      64'(bus_s.p_o), 64'd121);
        chk("sub_patdet", 64'(bus_s.patdet_o), 64'd0);
        chk("sub_ovf",    64'(bus_s.overflow_o), 64'd0);
        tick();
        chk("pat_p",      64'(bus_s.p_o), 64'd0);
        chk("pat_patdet", 64'(bus_s.patdet_o), 64'd1);
        chk("pat_wrap",   64'(bus_w.patdet_o), 64'd1);

        // CE stall of two cycles after the first edge
        set_op(1'b1, 18'd20, 18'd10, 18'd25, 48'd350, 2'b01, 2'b01, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        ce = 1'b0;
        tick();
        chk("ce_v2",      64'(bus_s.out_valid_o), 64'd0);
        chk("ce_hold_pd", 64'(bus_s.patdet_o), 64'd1);
        tick();
        chk("ce_v3",      64'(bus_s.out_valid_o), 64'd0);
        chk("ce_bcout",   64'(bus_s.bcout_o), 64'd10);
        ce = 1'b1;
        tick();
        chk("ce_v4",      64'(bus_s.out_valid_o), 64'd0);
        chk("ce_p4",      64'(bus_s.p_o), 64'd0);
        tick();
        chk("ce_v5",      64'(bus_s.out_valid_o), 64'd1);
        chk("ce_p5",      64'(bus_s.p_o), 64'd1051);
        chk("ce_pd5",     64'(bus_s.patdet_o), 64'd0);
        ce = 1'b0;
        tick();
        chk("ce_vhold",   64'(bus_s.out_valid_o), 64'd1);
        chk("ce_phold",   64'(bus_s.p_o), 64'd1051);
        ce = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsp_mac_slice.md
# dsp_mac_slice

Parametrised, fully pipelined signed multiply-accumulate slice: the next-generation arithmetic tile after the fixed-width 18x18 DSP slice. It provides a pre-adder, multiplier, post-adder/accumulator and cascade ports, and adds four things the fixed slice lacks: configurable widths, valid tracking, overflow saturation and pattern detect. Instances chain through BCOUT/PCOUT to form FIR and dot-product datapaths.

## Interface
- A_WIDTH, 18, multiplier A operand width (signed)
- B_WIDTH, 18, B and D operand width (signed; D shares B_WIDTH)
- P_WIDTH, 48, accumulator/result width; must be at least A_WIDTH+B_WIDTH+2
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- PATTERN, 0, P_WIDTH-bit pattern-detect value
- MASK, 0, P_WIDTH-bit mask; a 1 bit means "ignore" in pattern compare
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset; clears every register
- CE  in  1  global clock enable; 0 freezes all pipeline registers
- IN_VALID  in  1  qualifies the operands and opcode on this cycle
- A  in  A_WIDTH  multiplier operand
- B, D  in  B_WIDTH  pre-adder operands
- C  in  P_WIDTH  post-adder operand
- PCIN  in  P_WIDTH  cascade input, unregistered; sampled at stage 3
- CARRYIN  in  1  post-adder carry/borrow
- OPMODE  in  5  [1:0] PRESEL, [3:2] ZSEL, [4] SUB
- P, PCOUT  out  P_WIDTH  result register; PCOUT is identical to P
- BCOUT  out  B_WIDTH  stage-1 B register
- OUT_VALID  out  1  P, OVERFLOW and PATDET hold a new result
- OVERFLOW  out  1  the result was not representable in P_WIDTH
- PATDET  out  1  registered pattern match on P

## Operation
- Stage 1, when CE: register A, B, D, C, OPMODE, CARRYIN and IN_VALID.
- Stage 2: compute PRE (B_WIDTH+1 bits, exact, no wrap).
  - PRESEL 00 or 11: PRE = B1
  - PRESEL 01: PRE = D1+B1
  - PRESEL 10: PRE = D1−B1
  - Register M = A1*PRE (A_WIDTH+B_WIDTH+1 bits). Forward C, OPMODE, CARRYIN and valid.
- Stage 3: Z operand by ZSEL.
  - 00: 0
  - 01: C2
  - 10: current P (accumulate)
  - 11: PCIN
- Stage 3 exact sum in P_WIDTH+2 bits, with M sign-extended.
  - SUB=0: Z + M + CIN
  - SUB=1: Z − (M + CIN)
- Overflow: set when the exact sum falls outside the signed P_WIDTH range.
  - SATURATE=1: P clamps to 2^(P_WIDTH−1)−1 or −2^(P_WIDTH−1).
  - SATURATE=0: P takes the low P_WIDTH bits.
- P, OVERFLOW and PATDET update only when CE=1 and the stage-2 valid bit is 1. Otherwise they hold, so bubbles never disturb an accumulation.
- PATDET is computed from the next-P value and registered with P: ((Pnext ^ PATTERN) & ~MASK) == 0.
- OUT_VALID is the registered stage-2 valid bit when CE=1, and holds when CE=0.
- Accumulate with ZSEL=10 reads the P register at stage-3 time, so back-to-back accumulate transactions chain every cycle.

## Timing
- Latency: operands presented at edge n with IN_VALID=1 and CE=1 give P and OUT_VALID=1 after edge n+3. BCOUT updates after edge n+1.
- Throughput is one transaction per cycle. There is no backpressure; consumers must accept OUT_VALID pulses.
- CE=0 for k cycles delays every in-flight result by exactly k cycles, with values unchanged.
- Reset (RST_N low, any time, including mid-pipeline): immediately clears all stage registers, P, PCOUT, BCOUT, OUT_VALID, OVERFLOW and PATDET to 0. In-flight transactions are discarded.
- PATDET reads 0 out of reset even when the pattern would match 0. It asserts only after the first valid result.
- First valid input accepted on the first CE edge after RST_N deasserts.

## Test plan
- Reset mid-flight: issue 3 valid ops, pull RST_N low between edges → all outputs 0 at once; 3 cycles after release with no input, OUT_VALID stays 0.
- Pre-add path: A=20, B=10, D=25, C=350, PRESEL=01, ZSEL=01, SUB=0, CIN=1 → BCOUT=10 after 1 edge; P=1051, OUT_VALID=1 after 3 edges, OVERFLOW=0.
- Accumulate with bubble: P=0; valid A=3, B=4, PRESEL=00, ZSEL=10 on cycles 0, 1, 3, 4, with IN_VALID=0 on cycle 2 → P=12, 24, 24 (held, OUT_VALID=0), 36, 48.
- Saturation: C=0x7FFF_FFFF_FFFF, A=1, B=1, ZSEL=01, SUB=0 → P=0x7FFF_FFFF_FFFF, OVERFLOW=1. With SATURATE=0 → P=0x8000_0000_0000, OVERFLOW=1.
- Subtract and pattern: A=−3 (0x3FFFD), B=7, C=100, PRESEL=00, ZSEL=01, SUB=1, CIN=0 → P=121, PATDET=0. Then D=5, B=5, PRESEL=10, ZSEL=00 → P=0, PATDET=1.
- CE stall: valid op from the pre-add test, CE low for 2 cycles after its first edge → OUT_VALID appears 5 edges after issue; P=1051.
